// File: rtl/bubble_sort_engine.sv
// In-place bubble sort over a contiguous (wrapping) window of a 32x32 register file.
// Define BUBBLE_SORT_SIGNED_EN for a two's-complement compare; the default is unsigned.

module bubble_sort_rf (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);
    // Contents survive reset; the host owns initialisation.
    logic [31:0] r [0:31];

    always_ff @(posedge clk) begin
        if (we) r[waddr] <= wdata;
    end

    assign rdata_a = r[raddr_a];
    assign rdata_b = r[raddr_b];
endmodule

module bubble_sort_engine (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic [4:0] array,
    input  logic [4:0] length,
    output logic       done,
    output logic       busy,
    output logic [9:0] swap_count
);
    typedef enum logic [2:0] {IDLE, COMPARE, SWAP_A, SWAP_B, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  base_q, base_d;
    logic [4:0]  i_q, i_d;
    logic [4:0]  last_q, last_d;
    logic [31:0] tmp_q, tmp_d;
    logic        pass_swapped_q, pass_swapped_d;
    logic [9:0]  swap_count_q, swap_count_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [4:0]  i_nxt;
    logic [31:0] rd_a, rd_b;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        gt;

    assign i_nxt = i_q + 5'd1;

    bubble_sort_rf rf (
        .clk     (clock),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (i_q),
        .raddr_b (i_nxt),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

`ifdef BUBBLE_SORT_SIGNED_EN
    assign gt = $signed(rd_a) > $signed(rd_b);
`else
    assign gt = rd_a > rd_b;
`endif

    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        i_d            = i_q;
        last_d         = last_q;
        tmp_d          = tmp_q;
        pass_swapped_d = pass_swapped_q;
        swap_count_d   = swap_count_q;
        we             = 1'b0;
        waddr          = i_q;
        wdata          = rd_b;

        case (state_q)
            IDLE: begin
                if (go) begin
                    swap_count_d = '0;
                    if (length == 5'd0) begin
                        state_d = DONE;
                    end else begin
                        base_d         = array;
                        i_d            = array;
                        last_d         = array + length - 5'd1;
                        pass_swapped_d = 1'b0;
                        state_d        = COMPARE;
                    end
                end
            end
            COMPARE: begin
                if (i_q != last_q) begin
                    if (gt) begin
                        tmp_d   = rd_a;
                        state_d = SWAP_A;
                    end else begin
                        i_d = i_nxt;
                    end
                end else if (!pass_swapped_q || (last_q - 5'd1) == base_q) begin
                    state_d = DONE;
                end else begin
                    // Largest element of this pass has settled at last; shrink the window.
                    last_d         = last_q - 5'd1;
                    i_d            = base_q;
                    pass_swapped_d = 1'b0;
                end
            end
            SWAP_A: begin
                we      = 1'b1;
                waddr   = i_q;
                wdata   = rd_b;
                state_d = SWAP_B;
            end
            SWAP_B: begin
                we             = 1'b1;
                waddr          = i_nxt;
                wdata          = tmp_q;
                pass_swapped_d = 1'b1;
                swap_count_d   = swap_count_q + 10'd1;
                i_d            = i_nxt;
                state_d        = COMPARE;
            end
            DONE: begin
                if (!go) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d == COMPARE) || (state_d == SWAP_A) || (state_d == SWAP_B);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            base_q         <= '0;
            i_q            <= '0;
            last_q         <= '0;
            tmp_q          <= '0;
            pass_swapped_q <= 1'b0;
            swap_count_q   <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            i_q            <= i_d;
            last_q         <= last_d;
            tmp_q          <= tmp_d;
            pass_swapped_q <= pass_swapped_d;
            swap_count_q   <= swap_count_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
        end
    end

    assign done       = done_q;
    assign busy       = busy_q;
    assign swap_count = swap_count_q;
endmodule

// File: doc/bubble_sort_engine.md
# bubble_sort_engine

In-place bubble sort engine for a contiguous array held in the block's internal 32×32-bit register file. A host pulses `go` with a base register index and element count. The block then runs compare/swap passes over the register file until a pass completes with no swaps. It is the sorting counterpart to the array sort-check unit and shares its register-file storage model and its `go`/`done` handshake style.

## Interface
- No parameters; register file fixed at 32 entries × 32 bits, 5-bit indices.
- clock  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high; returns control to IDLE
- go  input  1  start request, sampled only in IDLE
- array  input  5  base register index of first element
- length  input  5  element count (0–31)
- done  output  1  sort complete, held until `go` low
- busy  output  1  high in any state other than IDLE/DONE
- swap_count  output  10  swaps performed in current/last sort

## Operation
- Internal register file instance `rf`, storage `r[0:31]`.
  - 2 combinational read ports, 1 synchronous write port.
  - Benches preload and inspect it hierarchically via `<inst>.rf.r[i]`.
  - `rf` is never cleared by reset.
- Index arithmetic is 5-bit modulo 32. Arrays wrap past r[31] to r[0].
- Registered state: `base`, `i`, `last`, `tmp[31:0]`, `pass_swapped`, `swap_count`.
- States:
  - IDLE
    - If go && length==0: enter DONE.
    - If go && length!=0: base=i=array; last=array+length-1; pass_swapped=0; swap_count=0; enter COMPARE.
    - `array`/`length` are ignored after this sample.
  - COMPARE, when i != last:
    - If r[i] > r[i+1]: tmp=r[i]; enter SWAP_A.
    - Otherwise: i=i+1.
  - COMPARE, when i == last (pass end):
    - If !pass_swapped or last-1 == base: enter DONE.
    - Otherwise: last=last-1; i=base; pass_swapped=0; stay in COMPARE.
  - SWAP_A: write r[i]=r[i+1]; enter SWAP_B.
  - SWAP_B: write r[i+1]=tmp; pass_swapped=1; swap_count+=1; i=i+1; enter COMPARE.
  - DONE: done=1; go back to IDLE when go==0.
- `go` asserted while busy or in DONE is ignored.
- Comparison is unsigned by default (see Configuration).

## Timing
- Reset values: done=0, busy=0, swap_count=0, state IDLE.
- Cycle costs, with edge 0 = the edge that samples `go`:
  - Each non-swapping compare: 1 cycle.
  - Each swapping compare: 3 cycles.
  - Each pass-end check: 1 cycle.
- length 0: done high after edge 0.
- length 1: done high after edge 1.
- Sorted length-N array: done high after edge N.
- done and busy are registered, so they change only on clock edges. busy falls on the same edge that done rises.
- Register file writes become visible to the read ports on the next cycle. No same-cycle forwarding is needed, because SWAP_B reads nothing.
- swap_count is stable whenever done=1. It holds its value through IDLE and clears only on the next accepted `go` or on reset.
- Reset mid-sort: next edge returns to IDLE with done=busy=swap_count=0. A partially swapped array is left as-is. A half-finished swap (after SWAP_A) may leave a duplicated value; this is acceptable.

## Configuration
- `BUBBLE_SORT_SIGNED_EN`
  - Defined: the compare treats r[i] and r[i+1] as two's-complement signed.
  - Undefined: the compare is unsigned.
- No other behaviour changes.

## Test plan
- Sorted: preload r[i]=i; array=11, length=5, go → done after edge 5; swap_count=0; r[11..15] unchanged.
- Partial: r[2..6]=1,2,3,2,5; array=2, length=5 → r[2..6]=1,2,2,3,5; swap_count=1; done held until go drops, then IDLE.
- Reverse: r[20..24]=5,4,3,2,1; array=20, length=5 → r[20..24]=1,2,3,4,5; swap_count=10.
- Wrap and degenerate lengths:
  - r[30],r[31],r[0],r[1]=9,8,7,6; array=30, length=4 → 6,7,8,9; swap_count=6.
  - length=0 → done after edge 0; length=1 → done after edge 1; rf unchanged in both cases.
- Reset mid-sort: start the reverse case, assert reset for one cycle at edge 4 → done=busy=swap_count=0. A fresh go then completes with r[20..24] sorted ascending.
- Signed: r[3]=32'hFFFFFFFF, r[4]=1; array=3, length=2.
  - With macro: no swap.
  - Without macro: swapped; swap_count=1.
